prog_sequencer: RTL and testbench

Program-flow controller for the 9-bit core. It owns the program counter, the start/done handshake with the test bench, and a 32-entry branch-target lookup table. Each cycle it consumes the decoder's flow-control strobes (GotoEn, Jump2En, BranchEn, Ack) plus the ALU Zero flag and selects the next PC. It sits between Ctrl/ALU and the instruction ROM address input.

---
 rtl/prog_sequencer.sv | 141 ++++++++++++++
 tb/tb_prog_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : Program-flow controller for the 9-bit core. Owns the PC, the
//               start/done handshake and a 32-entry branch-target LUT.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5,
    parameter int CYC_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Ack,
    input  logic              GotoEn,
    input  logic              Jump2En,
    input  logic              BranchEn,
    input  logic              Zero,
    input  logic [LUT_AW-1:0] TargetIdx,
    input  logic [5:0]        RelOffset,
    input  logic              LutWrEn,
    input  logic [LUT_AW-1:0] LutWrAddr,
    input  logic [PC_W-1:0]   LutWrData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic              Fault,
    output logic [CYC_W-1:0]  CycleCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic             r_start_q;
    logic             w_launch;
    logic             w_lut_we;
    logic [PC_W-1:0]  w_seq_pc;
    logic [PC_W-1:0]  w_rel_pc;
    logic [PC_W-1:0]  w_lut_rd;
    logic [PC_W-1:0]  r_lut [2**LUT_AW];

    assign w_launch = r_start_q & ~Start;
    assign w_seq_pc = r_pc + 1'b1;
    assign w_rel_pc = r_pc + {{(PC_W-6){RelOffset[5]}}, RelOffset};
    assign w_lut_rd = r_lut[TargetIdx];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cyc_nxt   = r_cyc;
        w_fault_nxt = r_fault;
        w_lut_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = '0;
                w_lut_we = LutWrEn & ~Reset;
                if (w_launch) begin
                    w_state_nxt = S_RUN;
                    w_cyc_nxt   = '0;
                    w_fault_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (Start) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else if (!Stall) begin
                    if (r_cyc != '1) begin
                        w_cyc_nxt = r_cyc + 1'b1;
                    end
                    if (Ack) begin
                        w_state_nxt = S_DONE;
                    end else if (GotoEn || (Jump2En && Zero)) begin
                        w_pc_nxt = w_lut_rd;
                    end else if (BranchEn && Zero) begin
                        w_pc_nxt = w_rel_pc;
                    end else if (r_pc == '1) begin
                        // Sequential step past the last ROM word: stop and flag it.
                        w_state_nxt = S_DONE;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_seq_pc;
                    end
                end
            end
            S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cyc     <= '0;
            r_fault   <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cyc     <= w_cyc_nxt;
            r_fault   <= w_fault_nxt;
            r_start_q <= Start;
        end
    end

    // Target table keeps its contents across reset.
    always_ff @(posedge Clk) begin
        if (w_lut_we) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

    assign ProgCtr    = r_pc;
    assign Running    = (r_state == S_RUN);
    assign Done       = (r_state == S_DONE);
    assign Fault      = r_fault;
    assign CycleCount = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Directed table-driven bench for prog_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stall, ack, goto_en, jump2_en, branch_en, zero;
    logic [4:0] target_idx, lut_wr_addr;
    logic [5:0] rel_offset;
    logic       lut_wr_en;
    logic [9:0] lut_wr_data;
    logic [9:0] prog_ctr;
    logic       running, done, fault;
    logic [15:0] cycle_count;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic st, sl, ak, gt, j2, br, z;
        logic [4:0] idx;
        logic [5:0] rel;
        logic we;
        logic [4:0] wa;
        logic [9:0] wd;
        logic [9:0] pc;
        logic run, dn, flt;
        logic [15:0] cyc;
    } vec_t;

    vec_t tbl[$];

    prog_sequencer #(.PC_W(10), .LUT_AW(5), .CYC_W(16)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Stall(stall), .Ack(ack),
        .GotoEn(goto_en), .Jump2En(jump2_en), .BranchEn(branch_en), .Zero(zero),
        .TargetIdx(target_idx), .RelOffset(rel_offset), .LutWrEn(lut_wr_en),
        .LutWrAddr(lut_wr_addr), .LutWrData(lut_wr_data), .ProgCtr(prog_ctr),
        .Running(running), .Done(done), .Fault(fault), .CycleCount(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, sl, ak, gt, j2, br, z,
                                input logic [4:0] idx, input logic [5:0] rel,
                                input logic we, input logic [4:0] wa, input logic [9:0] wd,
                                input logic [9:0] pc, input logic run, dn, flt,
                                input logic [15:0] cyc);
        vec_t v;
        v.st = st; v.sl = sl; v.ak = ak; v.gt = gt; v.j2 = j2; v.br = br; v.z = z;
        v.idx = idx; v.rel = rel; v.we = we; v.wa = wa; v.wd = wd;
        v.pc = pc; v.run = run; v.dn = dn; v.flt = flt; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        start = v.st; stall = v.sl; ack = v.ak; goto_en = v.gt; jump2_en = v.j2;
        branch_en = v.br; zero = v.z; target_idx = v.idx; rel_offset = v.rel;
        lut_wr_en = v.we; lut_wr_addr = v.wa; lut_wr_data = v.wd;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] pc, input logic run, dn, flt,
                           input logic [15:0] cyc);
        chk({tag, " pc"}, 32'(prog_ctr), 32'(pc));
        chk({tag, " running"}, 32'(running), 32'(run));
        chk({tag, " done"}, 32'(done), 32'(dn));
        chk({tag, " fault"}, 32'(fault), 32'(flt));
        chk({tag, " cycles"}, 32'(cycle_count), 32'(cyc));
    endtask

    initial begin
        // st sl ak gt j2 br z idx rel we wa wd | pc run dn flt cyc
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 1,3,10'h040, 10'h000,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 1,4,10'h010, 10'h000,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 1,5,10'h3FF, 10'h000,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 1,6,10'h002, 10'h000,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,1,0,0,0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'(k),1,0,0,16'(k)));
        tbl.push_back(mk(0,0,0,1,0,0,0, 3,6'h00, 0,0,10'h000, 10'h040,1,0,0,6));
        tbl.push_back(mk(0,0,0,0,1,0,0, 3,6'h00, 0,0,10'h000, 10'h041,1,0,0,7));
        tbl.push_back(mk(0,0,0,0,1,0,1, 3,6'h00, 0,0,10'h000, 10'h040,1,0,0,8));
        tbl.push_back(mk(0,0,0,1,0,0,0, 4,6'h00, 0,0,10'h000, 10'h010,1,0,0,9));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,6'h3C, 0,0,10'h000, 10'h00C,1,0,0,10));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,6'h1F, 0,0,10'h000, 10'h02B,1,0,0,11));
        tbl.push_back(mk(0,0,0,1,0,0,0, 6,6'h00, 0,0,10'h000, 10'h002,1,0,0,12));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,6'h3C, 0,0,10'h000, 10'h3FE,1,0,0,13));
        tbl.push_back(mk(0,0,0,0,0,1,0, 0,6'h3C, 0,0,10'h000, 10'h3FF,1,0,0,14));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h3FF,0,1,1,15));
        tbl.push_back(mk(0,0,0,1,0,0,0, 3,6'h00, 0,0,10'h000, 10'h3FF,0,1,1,15));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,0,0,1,15));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h001,1,0,0,1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,0,1,0,0,0, 3,6'h00, 0,0,10'h000, 10'h001,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 1,3,10'h100, 10'h002,1,0,0,2));
        tbl.push_back(mk(0,0,0,1,0,0,0, 3,6'h00, 0,0,10'h000, 10'h040,1,0,0,3));
        tbl.push_back(mk(0,0,0,1,0,1,1, 4,6'h3C, 0,0,10'h000, 10'h010,1,0,0,4));
        tbl.push_back(mk(0,0,0,0,1,1,1, 3,6'h05, 0,0,10'h000, 10'h040,1,0,0,5));
        tbl.push_back(mk(0,0,1,1,0,1,1, 4,6'h3C, 0,0,10'h000, 10'h040,0,1,0,6));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,0,0,0,6));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h001,1,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 10'h000,0,0,0,1));

        reset = 1'b1;
        apply(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 10'h000, 0, 0, 0, 16'h0000);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            @(posedge clk);
            #1 chk_all($sformatf("v%0d", i), tbl[i].pc, tbl[i].run, tbl[i].dn, tbl[i].flt, tbl[i].cyc);
        end

        // Relaunch and loop on a LUT target long enough to saturate the counter.
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0, 0,6'h00, 0,0,10'h000, 0,0,0,0,0));
        @(posedge clk);
        #1 chk_all("relaunch", 10'h000, 1, 0, 0, 16'h0000);
        @(negedge clk);
        goto_en = 1'b1; target_idx = 5'd3;
        repeat (65535) @(posedge clk);
        #1 chk_all("sat", 10'h040, 1, 0, 0, 16'hFFFF);
        @(posedge clk);
        #1 chk_all("sat hold", 10'h040, 1, 0, 0, 16'hFFFF);

        // Reset asserted during a stall wins over everything.
        @(negedge clk);
        stall = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 chk_all("reset mid-stall", 10'h000, 0, 0, 0, 16'h0000);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; goto_en = 1'b0;
        @(posedge clk);
        #1 chk_all("post reset", 10'h000, 0, 0, 0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
